mem_port_lat: RTL and testbench
===============================

# mem_port_lat

Parametrised single-port memory model with a request/grant/rvalid bus interface, configurable grant delay, fixed read latency, an outstanding-request limit and a side preload port. It replaces the ad-hoc instruction/data SRAM models and the one-cycle registered grant at the core's memory ports, so latency-sensitive runs can sweep bus timing without editing the top level. One instance serves one core port, either instruction or data.

## Interface
- DataWidth, 32: word width in bits; multiple of 8, at least 16.
- Depth, 1024: number of words; power of two.
- GntDelay, 0: cycles `req_i` must be held before `gnt_o` can rise (0..7).
- RdLatency, 1: cycles from grant to `rvalid_o` (1..8).
- MaxOutstanding, 2: maximum accepted, unretired requests (1..RdLatency).
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  1  request valid.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  DataWidth/8  byte enables (writes only).
- addr_i  in  32  byte address.
- wdata_i  in  DataWidth  write data.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid.
- rdata_o  out  DataWidth  read data; 0 for writes and errors.
- err_o  out  1  response error, qualified by `rvalid_o`.
- ld_we_i  in  1  preload write strobe.
- ld_be_i  in  DataWidth/8  preload byte enables.
- ld_addr_i  in  32  preload byte address.
- ld_wdata_i  in  DataWidth  preload data.

## Operation
- Derived values: BW = DataWidth/8, OB = log2(BW), AW = log2(Depth).
- Word index is `addr[OB+AW-1:OB]`.
- An address is in error if `addr[OB-1:0] != 0`, or if any bit at or above OB+AW is set.
- Wait counter: increments each cycle `req_i` is high without a grant, saturating at GntDelay. It clears when `req_i` is low and on grant.
- `gnt_o = req_i & (wait_cnt == GntDelay) & (outstanding < MaxOutstanding) & !ld_we_i`. This path is combinational.
- On grant of a valid write, bytes with `be_i[k]` set are written at the clock edge.
- On grant of a valid read, the word is sampled at the clock edge. A later write does not alter an in-flight read.
- On grant of an error address, there is no memory access; the response carries `err_o=1` and `rdata_o=0`.
- The response pipeline has RdLatency stages, each holding {valid, err, data}. Responses retire strictly in grant order.
- `outstanding` counts valid pipeline entries.
  - +1 on grant, −1 on retire.
  - Grant and retire in the same cycle leave it unchanged.
- Preload: when `ld_we_i` is high, the enabled bytes at the `ld_addr_i` word are written. An out-of-range or misaligned `ld_addr_i` is ignored silently. While `ld_we_i` is high, `gnt_o` is held at 0, so bus and preload writes never conflict in the same cycle.
- Memory contents are not reset.

## Timing
- Reset values: `gnt_o=0` while reset is held, `rvalid_o=0`, `rdata_o=0`, `err_o=0`, `wait_cnt=0`, `outstanding=0`.
- Reset mid-operation: all in-flight responses are discarded immediately. No `rvalid_o` is produced for them after reset release. Memory writes already committed remain.
- With GntDelay=0, a request presented with free capacity is granted in the same cycle.
- Grant latency: a request continuously held from cycle t is granted at the earliest cycle t+GntDelay at which capacity is available.
- Response: a request granted at cycle t produces `rvalid_o` in cycle t+RdLatency. `rvalid_o` is high for exactly one cycle per request.
- Throughput: one grant per cycle when GntDelay=0 and MaxOutstanding=RdLatency.
- The master must hold `req_i`, `we_i`, `be_i`, `addr_i` and `wdata_i` stable until `gnt_o` is high. Dropping `req_i` before grant cancels the request and clears `wait_cnt`.
- Responses are not back-pressured. The master must accept `rvalid_o` in every cycle.
- `err_o` and `rdata_o` hold their last values when `rvalid_o=0`. Only their values with `rvalid_o=1` are checked.

## Test plan
- Preload and read, Depth=1024, RdLatency=2, GntDelay=0. Stimulus: preload 0xDEADBEEF at 0x10; read 0x10 at cycle 5. Required: `gnt_o` high in cycle 5; `rvalid_o` high in cycle 7 with `rdata_o=0xDEADBEEF`, `err_o=0`.
- Byte-enable write. Stimulus: write 0x11223344 with `be=4'b0101` over 0xFFFFFFFF; then read back. Required: `rdata_o=0xFF22FF44`.
- Grant delay, GntDelay=3. Stimulus: `req_i` held from cycle 0. Required: `gnt_o` high only in cycle 3. Stimulus: `req_i` dropped at cycle 2. Required: no grant; counter restarts at the next request.
- Outstanding limit, MaxOutstanding=2, RdLatency=4. Stimulus: 4 back-to-back reads from cycle 0. Required: grants at cycles 0, 1, 4, 5; `rvalid_o` at cycles 4, 5, 8, 9, in order.
- Errors. Stimulus: read 0x1002 (misaligned), then read 0x1000 (out of range, Depth=1024). Required: both responses have `err_o=1`, `rdata_o=0`; memory is unchanged. Stimulus: `ld_we_i` high during `req_i`. Required: `gnt_o=0` for that cycle.
- Reset mid-flight. Stimulus: assert `rst_i` one cycle after a read grant with RdLatency=3. Required: no `rvalid_o` for that read; all outputs 0 during reset; a new request after release works.

Source files
------------

// File: rtl/mem_port_lat.sv
// Single-port memory model behind a req/gnt/rvalid bus: programmable grant delay,
// fixed read latency, capped outstanding requests and a side preload port.
module mem_port_lat #(
   parameter int DataWidth      = 32,
   parameter int Depth          = 1024,
   parameter int GntDelay       = 0,
   parameter int RdLatency      = 1,
   parameter int MaxOutstanding = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_i,
   input  logic                   we_i,
   input  logic [DataWidth/8-1:0] be_i,
   input  logic [31:0]            addr_i,
   input  logic [DataWidth-1:0]   wdata_i,
   output logic                   gnt_o,
   output logic                   rvalid_o,
   output logic [DataWidth-1:0]   rdata_o,
   output logic                   err_o,
   input  logic                   ld_we_i,
   input  logic [DataWidth/8-1:0] ld_be_i,
   input  logic [31:0]            ld_addr_i,
   input  logic [DataWidth-1:0]   ld_wdata_i
);

   localparam int BW  = DataWidth / 8;
   localparam int OB  = $clog2(BW);
   localparam int AW  = $clog2(Depth);
   localparam int WCW = 3;
   localparam int OCW = 4;
   localparam logic [WCW-1:0] GNT_DLY = WCW'(GntDelay);
   localparam logic [OCW-1:0] MAX_OUT = OCW'(MaxOutstanding);

   // Misaligned, or any address bit above the word-index field set.
   function automatic logic addr_bad(input logic [31:0] a);
      return (a[OB-1:0] != '0) || ((a >> (OB + AW)) != 32'd0);
   endfunction

   function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
      return a[OB+AW-1:OB];
   endfunction

   logic [DataWidth-1:0] mem_q [Depth];

   logic [WCW-1:0]       wait_q, wait_d;
   logic [OCW-1:0]       out_q, out_d;
   logic [RdLatency-1:0] v_q, e_q;
   logic [DataWidth-1:0] d_q [RdLatency];

   logic [RdLatency-1:0] in_v, in_e;
   logic [DataWidth-1:0] in_d [RdLatency];
   logic                 req_bad, ld_bad, gnt, retire;

   assign req_bad = addr_bad(addr_i);
   assign ld_bad  = addr_bad(ld_addr_i);
   assign gnt     = req_i & !rst_i & !ld_we_i & (wait_q == GNT_DLY) & (out_q < MAX_OUT);
   assign gnt_o   = gnt;

   // An entry retires from the count as it moves into the output stage.
   assign retire  = in_v[RdLatency-1];

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      wait_d = wait_q;
      if (!req_i || gnt) begin
         wait_d = '0;
      end else if (wait_q != GNT_DLY) begin
         wait_d = wait_q + WCW'(1);
      end
      out_d = out_q + OCW'(gnt) - OCW'(retire);
   end

   always_comb begin
      in_v[0] = gnt;
      in_e[0] = req_bad;
      in_d[0] = (req_bad || we_i) ? '0 : mem_q[word_idx(addr_i)];
      for (int i = 1; i < RdLatency; i++) begin
         in_v[i] = v_q[i-1];
         in_e[i] = e_q[i-1];
         in_d[i] = d_q[i-1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wait_q <= '0;
         out_q  <= '0;
         v_q    <= '0;
         e_q    <= '0;
         for (int i = 0; i < RdLatency; i++) begin
            d_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking so every stage captures its predecessor's pre-edge value.
         wait_q <= wait_d;
         out_q  <= out_d;
         v_q    <= in_v;
         // Payload only moves with a valid entry, so the outputs hold between responses.
         for (int i = 0; i < RdLatency; i++) begin
            if (in_v[i]) begin
               e_q[i] <= in_e[i];
               d_q[i] <= in_d[i];
            end
         end
      end
   end

   // NOTE: the array has no reset; contents survive rst_i and power up undefined.
   always_ff @(posedge clk_i) begin
      if (gnt && we_i && !req_bad) begin
         for (int k = 0; k < BW; k++) begin
            if (be_i[k]) mem_q[word_idx(addr_i)][8*k +: 8] <= wdata_i[8*k +: 8];
         end
      end
      if (ld_we_i && !ld_bad) begin
         for (int k = 0; k < BW; k++) begin
            if (ld_be_i[k]) mem_q[word_idx(ld_addr_i)][8*k +: 8] <= ld_wdata_i[8*k +: 8];
         end
      end
   end

   assign rvalid_o = v_q[RdLatency-1];
   assign err_o    = e_q[RdLatency-1];
   assign rdata_o  = d_q[RdLatency-1];

endmodule

// File: tb/tb_mem_port_lat.sv
// Directed bench for mem_port_lat: three instances with different bus timing,
// a per-cycle vector table plus hand-written grant-delay, limit and reset sequences.
module tb_mem_port_lat;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        ld_we;
      logic [3:0]  ld_be;
      logic [31:0] ld_addr;
      logic [31:0] ld_wdata;
   } bus_in_t;

   typedef struct {
      bus_in_t     b;
      logic        gnt;
      logic        rv;
      logic [31:0] rd;
      logic        er;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   bus_in_t     in_s     [3];
   logic        gnt_w    [3];
   logic        rvalid_w [3];
   logic        err_w    [3];
   logic [31:0] rdata_w  [3];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   // Instance 0: GntDelay 0, RdLatency 2. Instance 1: GntDelay 3, RdLatency 3.
   // Instance 2: GntDelay 0, RdLatency 4. All cap outstanding requests at 2.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_port_lat #(
         .DataWidth      (32),
         .Depth          (1024),
         .GntDelay       ((g == 1) ? 3 : 0),
         .RdLatency      ((g == 0) ? 2 : ((g == 1) ? 3 : 4)),
         .MaxOutstanding (2)
      ) u_dut (
         .clk_i      (clk),
         .rst_i      (rst),
         .req_i      (in_s[g].req),
         .we_i       (in_s[g].we),
         .be_i       (in_s[g].be),
         .addr_i     (in_s[g].addr),
         .wdata_i    (in_s[g].wdata),
         .gnt_o      (gnt_w[g]),
         .rvalid_o   (rvalid_w[g]),
         .rdata_o    (rdata_w[g]),
         .err_o      (err_w[g]),
         .ld_we_i    (in_s[g].ld_we),
         .ld_be_i    (in_s[g].ld_be),
         .ld_addr_i  (in_s[g].ld_addr),
         .ld_wdata_i (in_s[g].ld_wdata)
      );
   end

   function automatic bus_in_t idle();
      bus_in_t b = '0;
      return b;
   endfunction

   function automatic bus_in_t rd(input logic [31:0] a);
      bus_in_t b = '0;
      b.req  = 1'b1;
      b.addr = a;
      return b;
   endfunction

   function automatic bus_in_t wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      bus_in_t b = '0;
      b.req   = 1'b1;
      b.we    = 1'b1;
      b.be    = be;
      b.addr  = a;
      b.wdata = d;
      return b;
   endfunction

   function automatic bus_in_t pl(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      bus_in_t b = '0;
      b.ld_we    = 1'b1;
      b.ld_be    = be;
      b.ld_addr  = a;
      b.ld_wdata = d;
      return b;
   endfunction

   function automatic vec_t mk(input bus_in_t b, input logic g, input logic v,
                               input logic [31:0] d, input logic e);
      vec_t r;
      r.b   = b;
      r.gnt = g;
      r.rv  = v;
      r.rd  = d;
      r.er  = e;
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // One bus cycle on instance g: drive, sample mid-cycle, advance past the next edge.
   task automatic cyc(input int g, input bus_in_t b, input logic eg, input logic ev,
                      input logic [31:0] ed, input logic ee, input string nm);
      in_s[g] = b;
      @(negedge clk);
      check({nm, " gnt"}, 32'(gnt_w[g]), 32'(eg));
      check({nm, " rvalid"}, 32'(rvalid_w[g]), 32'(ev));
      if (ev) begin
         check({nm, " rdata"}, rdata_w[g], ed);
         check({nm, " err"}, 32'(err_w[g]), 32'(ee));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[$];
      int   k;
      int   r;

      rst = 1'b1;
      for (int g = 0; g < 3; g++) in_s[g] = idle();
      in_s[0] = rd(32'h10);

      // Reset state, including a gated grant on a zero-delay port with req high.
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         check($sformatf("reset%0d gnt", g), 32'(gnt_w[g]), 32'd0);
         check($sformatf("reset%0d rvalid", g), 32'(rvalid_w[g]), 32'd0);
         check($sformatf("reset%0d rdata", g), rdata_w[g], 32'd0);
         check($sformatf("reset%0d err", g), 32'(err_w[g]), 32'd0);
      end
      @(posedge clk);
      #1;
      in_s[0] = idle();
      rst = 1'b0;

      // Instance 0 (RdLatency 2): one row per cycle, starting at cycle 0.
      tbl.push_back(mk(pl(32'h10, 4'hF, 32'hDEADBEEF), 0, 0, 0, 0));
      tbl.push_back(mk(pl(32'h20, 4'hF, 32'hFFFFFFFF), 0, 0, 0, 0));
      tbl.push_back(mk(pl(32'h22, 4'hF, 32'hCAFEF00D), 0, 0, 0, 0));
      begin
         bus_in_t b = rd(32'h10);
         b.ld_we   = 1'b1;
         b.ld_be   = 4'h0;
         b.ld_addr = 32'h30;
         tbl.push_back(mk(b, 0, 0, 0, 0));
      end
      tbl.push_back(mk(idle(), 0, 0, 0, 0));
      tbl.push_back(mk(rd(32'h10), 1, 0, 0, 0));
      tbl.push_back(mk(idle(), 0, 0, 0, 0));
      tbl.push_back(mk(wr(32'h20, 4'b0101, 32'h11223344), 1, 1, 32'hDEADBEEF, 0));
      tbl.push_back(mk(rd(32'h20), 1, 0, 0, 0));
      tbl.push_back(mk(rd(32'h1002), 1, 1, 32'h0, 0));
      tbl.push_back(mk(rd(32'h1000), 1, 1, 32'hFF22FF44, 0));
      tbl.push_back(mk(wr(32'h1010, 4'hF, 32'h0), 1, 1, 32'h0, 1));
      tbl.push_back(mk(rd(32'h10), 1, 1, 32'h0, 1));
      tbl.push_back(mk(idle(), 0, 1, 32'h0, 1));
      tbl.push_back(mk(idle(), 0, 1, 32'hDEADBEEF, 0));
      tbl.push_back(mk(idle(), 0, 0, 0, 0));
      foreach (tbl[i]) begin
         cyc(0, tbl[i].b, tbl[i].gnt, tbl[i].rv, tbl[i].rd, tbl[i].er, $sformatf("tbl%0d", i));
      end
      in_s[0] = idle();

      // Preload instances 1 and 2.
      for (int i = 0; i < 4; i++) begin
         in_s[1] = (i == 0) ? pl(32'h10, 4'hF, 32'hA5A50001) : idle();
         in_s[2] = pl(32'(4 * i), 4'hF, 32'hB0000000 + 32'(i));
         @(posedge clk);
         #1;
      end
      in_s[1] = idle();
      in_s[2] = idle();

      // Grant delay 3: held request granted only in cycle 3, response in cycle 6.
      for (int c = 0; c < 8; c++) begin
         cyc(1, (c <= 3) ? rd(32'h10) : idle(), c == 3, c == 6, 32'hA5A50001, 0,
             $sformatf("gdly c%0d", c));
      end

      // Dropping req at cycle 2 cancels; the retry from cycle 3 waits a full 3 cycles.
      for (int c = 0; c < 11; c++) begin
         cyc(1, (c <= 1 || (c >= 3 && c <= 6)) ? rd(32'h10) : idle(), c == 6, c == 9,
             32'hA5A50001, 0, $sformatf("cancel c%0d", c));
      end

      // Outstanding limit 2 with RdLatency 4: grants 0,1,4,5, responses 4,5,8,9 in order.
      k = 0;
      r = 0;
      for (int c = 0; c < 12; c++) begin
         logic eg;
         logic ev;
         eg = (c == 0 || c == 1 || c == 4 || c == 5);
         ev = (c == 4 || c == 5 || c == 8 || c == 9);
         cyc(2, (k < 4) ? rd(32'(4 * k)) : idle(), eg, ev, 32'hB0000000 + 32'(r), 0,
             $sformatf("limit c%0d", c));
         if (eg) k++;
         if (ev) r++;
      end
      in_s[2] = idle();

      // Reset one cycle after a grant on instance 1: the response is dropped.
      for (int c = 0; c < 4; c++) begin
         cyc(1, rd(32'h10), c == 3, 0, 0, 0, $sformatf("rstmid c%0d", c));
      end
      rst     = 1'b1;
      in_s[1] = idle();
      in_s[0] = rd(32'h10);
      @(negedge clk);
      check("rstmid i0 gnt", 32'(gnt_w[0]), 32'd0);
      check("rstmid i0 rdata", rdata_w[0], 32'd0);
      check("rstmid i1 rvalid", 32'(rvalid_w[1]), 32'd0);
      check("rstmid i1 rdata", rdata_w[1], 32'd0);
      check("rstmid i1 err", 32'(err_w[1]), 32'd0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      in_s[0] = idle();
      for (int c = 0; c < 4; c++) begin
         cyc(1, idle(), 0, 0, 0, 0, $sformatf("rstquiet c%0d", c));
      end
      for (int c = 0; c < 8; c++) begin
         cyc(1, (c <= 3) ? rd(32'h10) : idle(), c == 3, c == 6, 32'hA5A50001, 0,
             $sformatf("rstafter c%0d", c));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
